// File: rtl/data_memory_unit.sv
// data_memory_unit: executes committed LOAD/STORE/OUTPUT/INPUT requests against a synchronous
// data RAM and a byte-wide I/O pair, returning LOAD/INPUT results through a one-entry CDB slot.
// Optional feature: define DMEM_OUTPUT_FIFO_EN to buffer OUTPUT bytes in a TX_DEPTH-entry FIFO.
module data_memory_unit #(
   parameter int ADDR_W   = 12,
   parameter int TX_DEPTH = 8,
   parameter int DATA_W   = 32,
   parameter int RSV_ID_W = 4,
   parameter int INSTR_W  = 5,
   parameter int CDB_W    = RSV_ID_W + DATA_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_valid,
   input  logic [INSTR_W-1:0]  i_opcode,
   input  logic [RSV_ID_W-1:0] i_rsv_id,
   input  logic [DATA_W-1:0]   i_address,
   input  logic [DATA_W-1:0]   i_data,
   output logic                i_ready,
   output logic [CDB_W-1:0]    o_cdb,
   output logic                o_cdb_valid,
   input  logic                o_cdb_ready,
   output logic [7:0]          tx_data,
   output logic                tx_valid,
   input  logic                tx_ready,
   input  logic [7:0]          rx_data,
   input  logic                rx_valid,
   output logic                rx_ready
);
   localparam logic [INSTR_W-1:0] I_LOAD    = INSTR_W'(1);
   localparam logic [INSTR_W-1:0] I_LOADB   = INSTR_W'(2);
   localparam logic [INSTR_W-1:0] I_LOADR   = INSTR_W'(3);
   localparam logic [INSTR_W-1:0] I_LOADF   = INSTR_W'(4);
   localparam logic [INSTR_W-1:0] I_LOADBF  = INSTR_W'(5);
   localparam logic [INSTR_W-1:0] I_LOADRF  = INSTR_W'(6);
   localparam logic [INSTR_W-1:0] I_STORE   = INSTR_W'(7);
   localparam logic [INSTR_W-1:0] I_STOREB  = INSTR_W'(8);
   localparam logic [INSTR_W-1:0] I_STORER  = INSTR_W'(9);
   localparam logic [INSTR_W-1:0] I_STOREF  = INSTR_W'(10);
   localparam logic [INSTR_W-1:0] I_STOREBF = INSTR_W'(11);
   localparam logic [INSTR_W-1:0] I_STORERF = INSTR_W'(12);
   localparam logic [INSTR_W-1:0] I_OUTPUT  = INSTR_W'(13);
   localparam logic [INSTR_W-1:0] I_INPUT   = INSTR_W'(14);

   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] ram_q, in_q;
   logic [RSV_ID_W-1:0] tag_q;
   logic sel_q, is_load, is_store, is_out, is_in, slot_free, tx_can, acc, res;
   logic unused_addr_bits;

   assign addr = i_address[ADDR_W-1:0];
   assign unused_addr_bits = ^i_address[DATA_W-1:ADDR_W];
   assign o_cdb = {tag_q, sel_q ? ram_q : in_q};

   // decode opcode class and form the per-class acceptance handshake
   always_comb begin
      is_load   = i_opcode inside {I_LOAD, I_LOADB, I_LOADR, I_LOADF, I_LOADBF, I_LOADRF};
      is_store  = i_opcode inside {I_STORE, I_STOREB, I_STORER, I_STOREF, I_STOREBF, I_STORERF};
      is_out    = i_opcode == I_OUTPUT;
      is_in     = i_opcode == I_INPUT;
      slot_free = !o_cdb_valid || o_cdb_ready;
      i_ready   = is_load ? slot_free : is_out ? tx_can : is_in ? slot_free && rx_valid : 1'b1;
      acc       = i_valid && i_ready;
      res       = acc && (is_load || is_in);
      rx_ready  = acc && is_in;
   end

   // result slot: load/refresh only when free, hold while the consumer stalls
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_cdb_valid <= 1'b0;
         tag_q       <= '0;
         in_q        <= '0;
         sel_q       <= 1'b0;
      end else begin
         if (slot_free) o_cdb_valid <= res;
         if (res) begin
            tag_q <= i_rsv_id;
            sel_q <= is_load;
            in_q  <= DATA_W'(rx_data);
         end
      end
   end

   // data RAM: write on accepted store, read register enabled only by accepted load
   always_ff @(posedge clk) begin
      if (acc && is_store) mem[addr] <= i_data;
      if (acc && is_load) ram_q <= mem[addr];
   end

`ifdef DMEM_OUTPUT_FIFO_EN
   localparam int PW = $clog2(TX_DEPTH);
   logic [7:0] fifo [TX_DEPTH];
   logic [PW:0] wr_ptr, rd_ptr;
   logic full, pop;

   // FIFO status; the extra pointer bit separates full from empty
   always_comb begin
      full     = (wr_ptr ^ rd_ptr) == {1'b1, {PW{1'b0}}};
      tx_valid = wr_ptr != rd_ptr;
      tx_data  = tx_valid ? fifo[rd_ptr[PW-1:0]] : 8'd0;
      pop      = tx_valid && tx_ready;
      tx_can   = !full || tx_ready;
   end

   // FIFO pointers advance on push and pop
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (acc && is_out) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // FIFO storage written at the accepting edge
   always_ff @(posedge clk) begin
      if (acc && is_out) fifo[wr_ptr[PW-1:0]] <= i_data[7:0];
   end
`else
   localparam int unused_depth = TX_DEPTH;

   // zero-latency OUTPUT path straight to the TX pins
   always_comb begin
      tx_valid = i_valid && is_out;
      tx_data  = i_data[7:0];
      tx_can   = tx_ready;
   end
`endif
endmodule

// File: tb/tb_data_memory_unit.sv
// tb_data_memory_unit: randomized and directed checks of data_memory_unit against a behavioural model.
module tb_data_memory_unit;
   localparam int TXD = 8;
`ifdef DMEM_OUTPUT_FIFO_EN
   localparam bit FIFO = 1;
`else
   localparam bit FIFO = 0;
`endif
   localparam logic [4:0] LOAD = 5'd1, STORE = 5'd7, OUTP = 5'd13, INP = 5'd14;

   logic clk = 0, rst = 1;
   logic i_valid = 0, o_cdb_ready = 0, tx_ready = 0, rx_valid = 0;
   logic [4:0] i_opcode = 0;
   logic [3:0] i_rsv_id = 0;
   logic [31:0] i_address = 0, i_data = 0;
   logic [7:0] rx_data = 0;
   logic i_ready, o_cdb_valid, tx_valid, rx_ready;
   logic [35:0] o_cdb;
   logic [7:0] tx_data;

   data_memory_unit dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_opcode(i_opcode), .i_rsv_id(i_rsv_id),
      .i_address(i_address), .i_data(i_data), .i_ready(i_ready), .o_cdb(o_cdb),
      .o_cdb_valid(o_cdb_valid), .o_cdb_ready(o_cdb_ready), .tx_data(tx_data),
      .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready)
   );

   always #5 clk = ~clk;

   int total = 0, passed = 0;
   logic [31:0] m_mem [4096];
   bit m_known [4096];
   bit m_sv = 0, m_sknown = 0;
   logic [35:0] m_sval = 0;
   logic [7:0] m_q [$];
   logic [7:0] popped_q [$];
   logic [35:0] cons_q [$];
   bit last_rdy, last_rx, last_acc;

   task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", n, got, exp, $time);
   endtask

   function automatic int cls(input logic [4:0] op);
      return (op >= 1 && op <= 6) ? 1 : (op >= 7 && op <= 12) ? 2 : (op == 13) ? 3 : (op == 14) ? 4 : 0;
   endfunction

   task automatic step(input bit v, input logic [4:0] op, input logic [3:0] tag, input logic [31:0] a,
                       input logic [31:0] d, input bit cr, input bit rxv, input logic [7:0] rxd, input bit txr);
      int c;
      bit sf, er, etv;
      logic [7:0] etd;
      logic [11:0] w;
      i_valid = v; i_opcode = op; i_rsv_id = tag; i_address = a; i_data = d;
      o_cdb_ready = cr; rx_valid = rxv; rx_data = rxd; tx_ready = txr;
      #4;
      c = cls(op);
      sf = !m_sv || cr;
      er = (c == 1) ? sf : (c == 3) ? (FIFO ? (m_q.size() < TXD || txr) : txr) : (c == 4) ? (sf && rxv) : 1'b1;
      etv = FIFO ? (m_q.size() > 0) : (v && c == 3);
      etd = FIFO ? (etv ? m_q[0] : 8'd0) : d[7:0];
      chk("i_ready", i_ready, er);
      chk("rx_ready", rx_ready, v && er && c == 4);
      chk("cdb_valid", o_cdb_valid, m_sv);
      if (m_sv) begin
         chk("cdb_tag", o_cdb[35:32], m_sval[35:32]);
         if (m_sknown) chk("cdb_data", o_cdb[31:0], m_sval[31:0]);
      end
      chk("tx_valid", tx_valid, etv);
      if (etv) chk("tx_data", tx_data, etd);
      last_rdy = i_ready; last_rx = rx_ready; last_acc = v && er;
      @(posedge clk);
      if (m_sv && cr) begin cons_q.push_back(m_sval); m_sv = 0; end
      if (FIFO && m_q.size() > 0 && txr) popped_q.push_back(m_q.pop_front());
      w = a[11:0];
      if (last_acc) begin
         if (c == 1) begin m_sv = 1; m_sval = {tag, m_mem[w]}; m_sknown = m_known[w]; end
         if (c == 2) begin m_mem[w] = d; m_known[w] = 1; end
         if (c == 3 && FIFO) m_q.push_back(d[7:0]);
         if (c == 4) begin m_sv = 1; m_sval = {tag, 24'd0, rxd}; m_sknown = 1; end
      end
      #1;
   endtask

   initial begin
      int stall, cyc, n;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cdb_valid", o_cdb_valid, 0);
      chk("rst_cdb", o_cdb, 0);
      chk("rst_tx_valid", tx_valid, 0);
      i_opcode = LOAD;
      #1;
      chk("rst_i_ready_load", i_ready, 1);
      rst = 0;

      step(1, STORE, 0, 5, 32'hDEADBEEF, 1, 0, 0, 1);
      chk("store_no_result", o_cdb_valid, 0);
      step(1, LOAD, 3, 5, 0, 1, 0, 0, 1);
      chk("load5", {o_cdb_valid, o_cdb}, {1'b1, 4'd3, 32'hDEADBEEF});

      for (int i = 0; i < 4; i++) step(1, STORE, 0, i, 32'h100 + i, 1, 0, 0, 1);
      cons_q.delete();
      n = 0; stall = 0; cyc = 0;
      while (n < 4 && cyc < 20) begin
         step(1, LOAD, 4'(n + 1), n, 0, !(cyc == 1 || cyc == 2), 0, 0, 1);
         if (!last_rdy) stall++;
         if (last_acc) n++;
         cyc++;
      end
      step(0, 0, 0, 0, 0, 1, 0, 0, 1);
      chk("b2b_stalls", stall, 2);
      chk("b2b_cycles", cyc, 6);
      chk("b2b_count", cons_q.size(), 4);
      for (int i = 0; i < 4 && i < cons_q.size(); i++) chk("b2b_order", cons_q[i], {4'(i + 1), 32'h100 + i});

      step(1, LOAD, 5, 0, 0, 0, 0, 0, 1);
      step(1, STORE, 0, 9, 7, 0, 0, 0, 1);
      chk("stalled_store_ready", last_rdy, 1);
      step(0, 0, 0, 0, 0, 1, 0, 0, 1);
      step(1, LOAD, 6, 9, 0, 1, 0, 0, 1);
      chk("load9", o_cdb, {4'd6, 32'd7});

      for (int i = 0; i < 3; i++) begin
         step(1, INP, 7, 0, 0, 1, 0, 8'h99, 1);
         chk("input_wait_ready", last_rdy, 0);
      end
      step(1, INP, 7, 0, 0, 1, 1, 8'h41, 1);
      chk("input_ready", {last_rdy, last_rx}, 2'b11);
      chk("input_result", {o_cdb_valid, o_cdb}, {1'b1, 4'd7, 32'h41});
      step(0, INP, 7, 0, 0, 1, 1, 8'h42, 1);
      chk("input_single_pop", last_rx, 0);

      if (FIFO) begin
         for (int i = 0; i < 8; i++) begin
            step(1, OUTP, 0, 0, 32'h10 + i, 1, 0, 0, 0);
            chk("fifo_fill_ready", last_rdy, 1);
         end
         step(1, OUTP, 0, 0, 32'h18, 1, 0, 0, 0);
         chk("fifo_full_stall", last_rdy, 0);
         popped_q.delete();
         n = 0; cyc = 0;
         while (popped_q.size() < 9 && cyc < 40) begin
            step(!n[0], OUTP, 0, 0, 32'h18, 1, 0, 0, 1);
            if (last_acc && !n[0]) n = 1;
            cyc++;
         end
         chk("fifo_drain_count", popped_q.size(), 9);
         for (int i = 0; i < 9 && i < popped_q.size(); i++) chk("fifo_order", popped_q[i], 8'h10 + i);
         for (int i = 0; i < 3; i++) step(1, OUTP, 0, 0, 32'h60 + i, 1, 0, 0, 0);
      end else begin
         step(0, OUTP, 0, 0, 32'h5A, 1, 0, 0, 0);
         chk("tx_idle", tx_valid, 0);
         i_valid = 1;
         #1;
         chk("tx_comb_valid", {tx_valid, tx_data, i_ready}, {1'b1, 8'h5A, 1'b0});
         step(1, OUTP, 0, 0, 32'h5A, 1, 0, 0, 1);
      end

      step(0, 0, 0, 0, 0, 1, 0, 0, 0);
      step(1, LOAD, 2, 5, 0, 0, 0, 0, 0);
      i_valid = 0;
      #1;
      chk("pre_rst_valid", o_cdb_valid, 1);
      chk("pre_rst_tx", tx_valid, FIFO);
      rst = 1;
      #1;
      chk("async_rst_cdb_valid", o_cdb_valid, 0);
      chk("async_rst_tx_valid", tx_valid, 0);
      #1;
      rst = 0;
      m_sv = 0; m_q.delete();
      step(1, LOAD, 4, 5, 0, 1, 0, 0, 1);
      chk("ram_survives_rst", o_cdb, {4'd4, 32'hDEADBEEF});

      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 19)), 4'($urandom),
              ($urandom & 32'hFFFFF000) | $urandom_range(0, 15), $urandom,
              $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, 8'($urandom), $urandom_range(0, 1) != 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
